uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered 8-bit UART transmitter for the camera link. It accepts bytes from on-chip logic on a single-cycle strobe and queues them in a small FIFO. It serialises them onto `PinTX` as back-to-back 8N1 frames, with an optional parity bit. It is the outbound counterpart to the receive path: received bytes, and later RAM/image readout bytes, go out through this block without the source having to wait for each frame.

## Interface
- `CLK_FREQ`, default 50000000: `clk` frequency in Hz.
- `BAUD`, default 115200: line rate. The bit period is `DIV = CLK_FREQ/BAUD` clocks, integer-truncated, and `DIV` is at least 2.
- `DEPTH`, default 4: FIFO entries, a power of two, at least 2.
- `clk`, input, 1 bit: the single clock.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `dataIN`, input, 8 bits: byte to send, sampled when `flagIN_DataRedy` is high.
- `flagIN_DataRedy`, input, 1 bit: one-cycle write strobe. Held high, it writes once per cycle.
- `PinTX`, output, 1 bit: serial line, idle high.
- `busy`, output, 1 bit: high while a frame is on the line or the FIFO is non-empty.
- `fifo_full`, output, 1 bit: FIFO holds `DEPTH` entries.
- `overflow`, output, 1 bit: sticky flag, set when a strobe arrives while `fifo_full` is high.

## Operation
- **Reset values:** `PinTX`=1, `busy`=0, `fifo_full`=0, `overflow`=0. The FIFO is empty and the FSM is in IDLE.
- **Push:** on a rising edge where `flagIN_DataRedy`=1 and `fifo_full`=0, `dataIN` is written.
  - A push while `fifo_full`=1 is dropped and sets `overflow`. The FIFO contents are unchanged.
  - `overflow` clears only on `rst`.
- **Simultaneous push and pop:** allowed when not full. Occupancy is unchanged.
- **FSM states:** IDLE → START → DATA → (PARITY) → STOP → IDLE or START.
  - IDLE: `PinTX`=1. If the FIFO is non-empty, pop the head into the shift register, reset the bit counter, and go to START.
  - START: `PinTX`=0 for `DIV` clocks.
  - DATA: 8 bits, LSB first, each held for `DIV` clocks. A 3-bit index counts 0 to 7.
  - PARITY: present only with the parity option (see Configuration).
  - STOP: `PinTX`=1 for `DIV` clocks.
    - On the last stop clock, if the FIFO is non-empty, pop and go directly to START. There is no idle gap between frames.
    - Otherwise go to IDLE.
- **Baud counter:** counts 0 to `DIV-1` and is held at 0 in IDLE. Its width is `$clog2(DIV)`.
- **Reset mid-frame:** `PinTX` goes high immediately (asynchronously). The frame is truncated and queued bytes are discarded.

## Timing
- Push edge E on an idle block: `PinTX` falls at edge E+2. The FIFO is written at E and popped at E+1, and the START output is registered at E+2.
- Frame length: 10×`DIV` clocks, or 11×`DIV` with parity. Bit boundaries are exact, with no jitter.
- Back-to-back queued bytes: the next start bit begins on the clock immediately after the last stop-bit clock.
- `busy` drops on the same edge that the FSM enters IDLE with an empty FIFO.
- `fifo_full` is registered and reflects occupancy after each edge.
- `PinTX` is driven directly from a flop, with no combinational path to the pin.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: a PARITY state follows DATA and drives even parity (XOR of the 8 data bits) for `DIV` clocks. The frame is 11 bits (8E1).
  - Undefined: the PARITY state and its logic are absent. The frame is 10 bits (8N1).

## Test plan
- **Single byte:** with `CLK_FREQ`=16, `BAUD`=1 (`DIV`=16), push 0x55 once.
  - `PinTX` must fall 2 clocks after the push.
  - The line then reads 0,1,0,1,0,1,0,1,0,1, each level lasting 16 clocks.
  - `busy` is high for 160 clocks and then drops.
- **Back-to-back:** push 0xA3 then 0x0F on consecutive clocks.
  - Two frames follow, with stop(0xA3) immediately followed by start(0x0F), with zero idle clocks.
- **Overflow:** with `DEPTH`=4, push 0x01 to 0x06 on 6 consecutive clocks while idle.
  - 0x01 to 0x05 are transmitted in order.
  - 0x06 is dropped.
  - `fifo_full`=1 at the 6th edge, and `overflow`=1 and stays 1 after the line goes idle.
- **Reset mid-frame:** assert `rst` during DATA bit 3 of 0xFF with 2 bytes queued.
  - `PinTX`=1 immediately and `busy`=0.
  - No further frames follow after release.
- **Parity:** with `UART_TX_PARITY_EN` defined, send 0x07, then 0x03.
  - The parity bit is 1 for 0x07 and 0 for 0x03.
  - Each frame is 176 clocks long.
- **Continuous strobe:** hold `flagIN_DataRedy` high for 1 clock with `dataIN`=0x80.
  - Exactly one frame is sent, with bit 7 being the last data bit, which is 1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter with a small byte FIFO.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
module uart_tx_fifo #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dataIN,
  input  logic       flagIN_DataRedy,
  output logic       PinTX,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(DEPTH);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam logic [AW:0]   FULL_N = (AW+1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t state_q, state_d;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          tx_q, tx_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic       push;
  logic       pop;
  logic       bdone;
  logic [7:0] head;

  assign head = mem_q[rp_q];

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    pop     = 1'b0;
    tx_d    = 1'b1;
    bdone   = (baud_q == DIV_M1);

    if (state_q != S_IDLE) begin
      baud_d = bdone ? '0 : baud_q + 1'b1;
    end

    // tx_d follows state_q, so the line lags the FSM by one clock
    unique case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) pop = 1'b1;
      end
      S_START: begin
        tx_d = 1'b0;
        if (bdone) state_d = S_DATA;
      end
      S_DATA: begin
        tx_d = sh_q[0];
        if (bdone) begin
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PAR: begin
        tx_d = par_q;
        if (bdone) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bdone) begin
          if (cnt_q != '0) pop = 1'b1;
          else state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      sh_d    = head;
      bit_d   = '0;
      baud_d  = '0;
      state_d = S_START;
`ifdef UART_TX_PARITY_EN
      par_d   = ^head;
`endif
    end
  end

  always_comb begin
    push  = flagIN_DataRedy & ~full_q;
    mem_d = mem_q;
    if (push) mem_d[wp_q] = dataIN;
    wp_d  = push ? wp_q + 1'b1 : wp_q;
    rp_d  = pop  ? rp_q + 1'b1 : rp_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    full_d = (cnt_d == FULL_N);
    ovf_d  = ovf_q | (flagIN_DataRedy & full_q);
    busy_d = (state_d != S_IDLE) | (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign PinTX     = tx_q;
  assign busy      = busy_q;
  assign fifo_full = full_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: line-decoding scoreboard plus
// exact waveform checks on the timing corner cases.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int DEPTH    = 4;
  localparam int DIV      = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] dataIN = 8'h00;
  logic       flagIN_DataRedy = 1'b0;
  logic       PinTX, busy, fifo_full, overflow;

  uart_tx_fifo #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dataIN(dataIN),
    .flagIN_DataRedy(flagIN_DataRedy),
    .PinTX(PinTX),
    .busy(busy),
    .fifo_full(fifo_full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       p;
    int         gap;
  } vec_t;

  exp_t sb[$];
  bit   exp_bits[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, req);
  endtask

  // call at a negedge; strobe is sampled on the following posedge
  task automatic drive(input logic [7:0] b, input logic p, input bit keep);
    exp_t e;
    dataIN = b;
    flagIN_DataRedy = 1'b1;
    if (keep) begin
      e.d = b;
      e.p = p;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  function automatic void add_frame(input logic [7:0] b, input logic p);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    exp_bits.push_back(p);
`else
    if (p === 1'bx) exp_bits.push_back(1'b0);
`endif
    exp_bits.push_back(1'b1);
  endfunction

  task automatic wave_check(input string nm, input int skip);
    int bad;
    bad = 0;
    repeat (skip) @(negedge clk);
    foreach (exp_bits[i]) begin
      for (int j = 0; j < DIV; j++) begin
        @(negedge clk);
        if (PinTX !== exp_bits[i]) bad++;
      end
    end
    chk(nm, bad, 0);
    exp_bits.delete();
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, (n < 5000), 1);
    repeat (DIV) @(negedge clk);
  endtask

  task automatic quiet_check(input string nm, input int n);
    int lows;
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (PinTX !== 1'b1) lows++;
    end
    chk(nm, lows, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // receiver: decodes each frame at mid-bit and pops the scoreboard
  logic [7:0] m_d;
  logic       m_p, m_s;
  bit         m_ab;
  int         m_k;
  exp_t       m_e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && PinTX === 1'b0) begin
        m_ab = 0;
        m_d  = '0;
        m_p  = 1'b0;
        m_s  = 1'b0;
        for (int t = 1; t <= (FB-1)*DIV + DIV/2; t++) begin
          @(negedge clk);
          if (rst) m_ab = 1;
          if (t % DIV == DIV/2) begin
            m_k = t / DIV;
            if (m_k >= 1 && m_k <= 8) m_d[m_k-1] = PinTX;
            else if (m_k == FB-1) m_s = PinTX;
            else if (m_k == 9) m_p = PinTX;
          end
        end
        if (!m_ab) begin
          chk("frame_expected", (sb.size() != 0), 1);
          if (sb.size() != 0) begin
            m_e = sb.pop_front();
            chk("rx_data", m_d, m_e.d);
            chk("rx_stop", m_s, 1);
`ifdef UART_TX_PARITY_EN
            chk("rx_parity", m_p, m_e.p);
`endif
          end
        end
      end
    end
  end

  vec_t tbl[6];
  int   bad, bbad;

  initial begin
    tbl[0] = '{8'h00, 1'b0, 0};
    tbl[1] = '{8'hFF, 1'b0, 0};
    tbl[2] = '{8'h01, 1'b1, 400};
    tbl[3] = '{8'h80, 1'b1, 0};
    tbl[4] = '{8'h5A, 1'b0, 0};
    tbl[5] = '{8'h7F, 1'b1, 0};

    #1 rst = 1'b1;
    #1;
    chk("rst_tx", PinTX, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", overflow, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single byte: fall at E+2, busy for the 160-clock frame
    drive(8'h55, 1'b0, 1);
    flagIN_DataRedy = 1'b0;
    chk("busy_after_push", busy, 1);
    @(negedge clk);
    chk("tx_high_e1", PinTX, 1);
    add_frame(8'h55, 1'b0);
    bad  = 0;
    bbad = 0;
    for (int t = 0; t < FB*DIV; t++) begin
      @(negedge clk);
      if (t == 0) chk("tx_fall_e2", PinTX, 0);
      if (PinTX !== exp_bits[t/DIV]) bad++;
      if (t < FB*DIV-1 && busy !== 1'b1) bbad++;
    end
    exp_bits.delete();
    chk("single_wave", bad, 0);
    chk("busy_during", bbad, 0);
    chk("busy_drop", busy, 0);
    wait_idle("single_drain");

    // back-to-back frames with no idle gap
    drive(8'hA3, 1'b0, 1);
    drive(8'h0F, 1'b0, 1);
    flagIN_DataRedy = 1'b0;
    add_frame(8'hA3, 1'b0);
    add_frame(8'h0F, 1'b0);
    wave_check("b2b_wave", 0);
    wait_idle("b2b_drain");

    // table-driven bytes
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].d, tbl[i].p, 1);
      flagIN_DataRedy = 1'b0;
      repeat (tbl[i].gap) @(negedge clk);
    end
    wait_idle("tbl_drain");
    chk("tbl_sb_empty", sb.size(), 0);

    // overflow: sixth byte dropped
    for (int i = 1; i <= 5; i++) drive(8'(i), 1'b0, 1);
    chk("ovf_full_e5", fifo_full, 1);
    chk("ovf_clear_e5", overflow, 0);
    drive(8'h06, 1'b0, 0);
    flagIN_DataRedy = 1'b0;
    chk("ovf_full_e6", fifo_full, 1);
    chk("ovf_set_e6", overflow, 1);
    wait_idle("ovf_drain");
    chk("ovf_sticky", overflow, 1);
    chk("ovf_not_full", fifo_full, 0);
    do_reset();
    @(negedge clk);
    chk("ovf_rst_clear", overflow, 0);

    // reset during data bit 3 with two bytes queued
    drive(8'hFF, 1'b0, 0);
    drive(8'h11, 1'b0, 0);
    drive(8'h22, 1'b0, 0);
    flagIN_DataRedy = 1'b0;
    repeat (70) @(negedge clk);
    chk("mid_tx_low", PinTX, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_tx", PinTX, 1);
    chk("mid_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    quiet_check("mid_no_frames", 400);
    chk("mid_busy_after", busy, 0);

    // one-clock strobe gives exactly one frame
    drive(8'h80, 1'b1, 1);
    flagIN_DataRedy = 1'b0;
    add_frame(8'h80, 1'b1);
    wave_check("strobe_wave", 1);
    quiet_check("strobe_single", 300);
    wait_idle("strobe_drain");

`ifdef UART_TX_PARITY_EN
    drive(8'h07, 1'b1, 1);
    drive(8'h03, 1'b0, 1);
    flagIN_DataRedy = 1'b0;
    add_frame(8'h07, 1'b1);
    add_frame(8'h03, 1'b0);
    wave_check("parity_wave", 0);
    wait_idle("parity_drain");
`endif

    chk("final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
